pmem_arbiter: RTL and testbench

Two-port physical-memory arbiter between the instruction cache and data cache control blocks and the single physical memory port. Each cache presents whole-line (128-bit) read/write requests and holds them until it sees its own response. The arbiter grants one cache at a time and latches that cache's request for the full transaction. It then routes the memory response back to the granted cache only.

---
 rtl/lc3b_types.sv | 29 ++
 rtl/pmem_req_reg.sv | 22 ++
 rtl/pmem_arbiter.sv | 119 +++++++++++
 tb/tb_pmem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared types for the physical-memory arbiter.
// Line, word, FSM state, port id and the latched request bundle.
package lc3b_types;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    typedef logic [ADDR_W-1:0] lc3b_word;
    typedef logic [LINE_W-1:0] lc3b_line;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_I,
        GRANT_D
    } arb_state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } arb_port_t;

    // rw: 1 = write, 0 = read
    typedef struct packed {
        logic     rw;
        lc3b_word address;
        lc3b_line wdata;
    } pmem_req_t;

endpackage

// File: rtl/pmem_req_reg.sv
// Load-enabled holding register for the granted request.
// Synchronous active-low clear returns it to a zero read.
import lc3b_types::*;

module pmem_req_reg (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      load,
    input  pmem_req_t d,
    output pmem_req_t q
);

    // Capture the winning request on grant, clear on reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pmem_arbiter.sv
// I/D cache to physical memory arbiter: FSM, priority, resp demux.
// Build option PMEM_ARB_ROUND_ROBIN_EN: alternate ties, else D wins.
import lc3b_types::*;

module pmem_arbiter (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_pmem_read,
    input  logic              i_pmem_write,
    input  logic [ADDR_W-1:0] i_pmem_address,
    input  logic [LINE_W-1:0] i_pmem_wdata,
    output logic              i_pmem_resp,
    output logic [LINE_W-1:0] i_pmem_rdata,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    arb_state_t state;
    arb_state_t next_state;
    pmem_req_t  req_in;
    pmem_req_t  req_q;
    logic       load;
    logic       i_req;
    logic       d_req;
    logic       win_d;
    logic       gnt_i;
    logic       gnt_d;

    assign i_req = i_pmem_read | i_pmem_write;
    assign d_req = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    arb_port_t last_grant;

    // Remember which port won the most recent grant
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant <= PORT_D;
        end else if (load) begin
            last_grant <= win_d ? PORT_D : PORT_I;
        end
    end

    assign win_d = d_req & (~i_req | (last_grant == PORT_I));
`else
    assign win_d = d_req;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Arbitrate in IDLE, hold the grant until memory responds
    always_comb begin
        next_state     = state;
        load           = 1'b0;
        req_in.rw      = i_pmem_write;
        req_in.address = i_pmem_address;
        req_in.wdata   = i_pmem_wdata;
        unique case (state)
            IDLE: begin
                if (win_d) begin
                    load           = 1'b1;
                    req_in.rw      = d_pmem_write;
                    req_in.address = d_pmem_address;
                    req_in.wdata   = d_pmem_wdata;
                    next_state     = GRANT_D;
                end else if (i_req) begin
                    load       = 1'b1;
                    next_state = GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (pmem_resp) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    pmem_req_reg u_req (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .d       (req_in),
        .q       (req_q)
    );

    assign gnt_i = (state == GRANT_I);
    assign gnt_d = (state == GRANT_D);

    assign pmem_read    = (gnt_i | gnt_d) & ~req_q.rw;
    assign pmem_write   = (gnt_i | gnt_d) & req_q.rw;
    assign pmem_address = req_q.address;
    assign pmem_wdata   = req_q.wdata;

    // An aborting reset must not complete the transaction
    assign i_pmem_resp  = gnt_i & pmem_resp & reset_n;
    assign d_pmem_resp  = gnt_d & pmem_resp & reset_n;
    assign i_pmem_rdata = gnt_i ? pmem_rdata : '0;
    assign d_pmem_rdata = gnt_d ? pmem_rdata : '0;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Randomized and directed bench for pmem_arbiter.
// Reference model tracks owner and latched request per cycle.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i_pmem_read, i_pmem_write;
    logic [15:0]  i_pmem_address;
    logic [127:0] i_pmem_wdata;
    logic         i_pmem_resp;
    logic [127:0] i_pmem_rdata;
    logic         d_pmem_read, d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata;
    logic         d_pmem_resp;
    logic [127:0] d_pmem_rdata;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic         pmem_resp;
    logic [127:0] pmem_rdata;

    pmem_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_write   (i_pmem_write),
        .i_pmem_address (i_pmem_address),
        .i_pmem_wdata   (i_pmem_wdata),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_iresp = 0;
    int n_dresp = 0;

    // model: owner 0 = none, 1 = I, 2 = D
    int           m_own  = 0;
    int           m_last = 2;
    logic         m_rw   = 1'b0;
    logic [15:0]  m_addr = '0;
    logic [127:0] m_wd   = '0;
    logic         e_i, e_d;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    task automatic check(input string tag,
                         input logic [127:0] obs,
                         input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One cycle: drive memory side, check outputs, advance model
    task automatic tick(input logic pr, input logic [127:0] prd);
        logic busy, ir, dr;
        int   win;
        pmem_resp  = pr;
        pmem_rdata = prd;
        #2;
        busy = (m_own != 0);
        e_i  = (m_own == 1) && pr && reset_n;
        e_d  = (m_own == 2) && pr && reset_n;
        if (i_pmem_resp === 1'b1) n_iresp++;
        if (d_pmem_resp === 1'b1) n_dresp++;
        check("pmem_read", pmem_read, busy && !m_rw);
        check("pmem_write", pmem_write, busy && m_rw);
        check("pmem_address", pmem_address, m_addr);
        check("pmem_wdata", pmem_wdata, m_wd);
        check("i_resp", i_pmem_resp, e_i);
        check("d_resp", d_pmem_resp, e_d);
        check("i_rdata", i_pmem_rdata,
              (m_own == 1) ? prd : 128'h0);
        check("d_rdata", d_pmem_rdata,
              (m_own == 2) ? prd : 128'h0);
        if (!reset_n) begin
            m_own  = 0;
            m_last = 2;
            m_rw   = 1'b0;
            m_addr = '0;
            m_wd   = '0;
        end else if (busy) begin
            if (pr) m_own = 0;
        end else begin
            ir  = i_pmem_read | i_pmem_write;
            dr  = d_pmem_read | d_pmem_write;
            win = 0;
            if (ir && dr) win = (RR && m_last == 2) ? 1 : 2;
            else if (dr) win = 2;
            else if (ir) win = 1;
            if (win == 1) begin
                m_rw   = i_pmem_write;
                m_addr = i_pmem_address;
                m_wd   = i_pmem_wdata;
            end else if (win == 2) begin
                m_rw   = d_pmem_write;
                m_addr = d_pmem_address;
                m_wd   = d_pmem_wdata;
            end
            if (win != 0) begin
                m_own  = win;
                m_last = win;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_clients();
        i_pmem_read  = 1'b0;
        i_pmem_write = 1'b0;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
    endtask

    logic [127:0] a5;
    logic [127:0] ones;
    logic         exp_d;
    logic [2:0]   tie_tab;
    bit           i_act, d_act;
    int           r;

    initial begin
        a5   = {16{8'hA5}};
        ones = {32{4'h1}};
        idle_clients();
        i_pmem_address = '0;
        i_pmem_wdata   = '0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        pmem_resp      = 1'b0;
        pmem_rdata     = '0;
        reset_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // reset state, single I read
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h1230;
        tick(1'b0, '0);
        check("t1_read_n1", pmem_read, 1'b1);
        check("t1_addr", pmem_address, 16'h1230);
        tick(1'b0, '0);
        tick(1'b0, '0);
        tick(1'b1, a5);
        idle_clients();
        check("t1_iresp_cnt", n_iresp, 1);
        check("t1_dresp_cnt", n_dresp, 0);
        tick(1'b0, '0);

        // simultaneous I read / D write
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h0040;
        d_pmem_write   = 1'b1;
        d_pmem_address = 16'h0080;
        d_pmem_wdata   = ones;
        tick(1'b0, '0);
        check("t2_d_first", pmem_write, 1'b1);
        check("t2_d_wdata", pmem_wdata, ones);
        tick(1'b1, rnd_line());
        d_pmem_write = 1'b0;
        check("t2_dresp_cnt", n_dresp, 1);
        tick(1'b0, '0);
        check("t2_i_m2", pmem_read, 1'b1);
        check("t2_i_addr", pmem_address, 16'h0040);
        tick(1'b1, rnd_line());
        idle_clients();

        // three back-to-back ties
        tie_tab = RR ? 3'b101 : 3'b111;
        i_pmem_read  = 1'b1;
        d_pmem_write = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, '0);
            exp_d = tie_tab[2-k];
            check("t3_tie_win", pmem_write, exp_d);
            tick(1'b1, rnd_line());
        end
        d_pmem_write = 1'b0;
        tick(1'b0, '0);
        check("t3_i_after", pmem_read, 1'b1);
        tick(1'b1, rnd_line());
        idle_clients();
        tick(1'b0, '0);

        // address change mid-grant
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h0100;
        tick(1'b0, '0);
        d_pmem_address = 16'h0200;
        tick(1'b0, '0);
        check("t4_addr_held", pmem_address, 16'h0100);
        tick(1'b1, rnd_line());
        idle_clients();

        // reset during GRANT_I
        n_iresp        = 0;
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h0abc;
        tick(1'b0, '0);
        tick(1'b0, '0);
        reset_n = 1'b0;
        tick(1'b0, '0);
        reset_n = 1'b1;
        check("t5_rd_clr", pmem_read, 1'b0);
        check("t5_addr_clr", pmem_address, 16'h0);
        tick(1'b0, '0);
        check("t5_regrant", pmem_read, 1'b1);
        check("t5_no_iresp", n_iresp, 0);
        tick(1'b1, rnd_line());
        idle_clients();

        // stray response in IDLE
        n_iresp = 0;
        n_dresp = 0;
        tick(1'b1, rnd_line());
        tick(1'b0, '0);
        check("t6_no_resp", n_iresp + n_dresp, 0);
        check("t6_idle", pmem_read | pmem_write, 1'b0);

        // randomized traffic
        i_act = 0;
        d_act = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!i_act && $urandom_range(2) == 0) begin
                i_act = 1;
                r = $urandom_range(3);
                i_pmem_read    = (r != 1);
                i_pmem_write   = (r == 1 || r == 2);
                i_pmem_address = 16'($urandom);
                i_pmem_wdata   = rnd_line();
            end else if (i_act && $urandom_range(7) == 0) begin
                i_pmem_address = 16'($urandom);
            end
            if (!d_act && $urandom_range(2) == 0) begin
                d_act = 1;
                r = $urandom_range(3);
                d_pmem_read    = (r != 1);
                d_pmem_write   = (r == 1 || r == 2);
                d_pmem_address = 16'($urandom);
                d_pmem_wdata   = rnd_line();
            end else if (d_act && $urandom_range(15) == 0) begin
                d_pmem_read  = 1'b0;
                d_pmem_write = 1'b0;
            end
            reset_n = ($urandom_range(63) != 0);
            tick($urandom_range(2) == 0, rnd_line());
            if (e_i) begin
                i_act        = 0;
                i_pmem_read  = 1'b0;
                i_pmem_write = 1'b0;
            end
            if (e_d || (d_act && !d_pmem_read && !d_pmem_write)) begin
                d_act        = 0;
                d_pmem_read  = 1'b0;
                d_pmem_write = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
